// File: rtl/video_timing_gen.sv
// Raster timing generator for one progressive format: drives the {F,V,H,T} bus
// plus the current sample/line position and a completed-frame counter.
module video_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_TOTAL  = 2200,
    parameter int V_ACTIVE = 1080,
    parameter int V_TOTAL  = 1125
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cen_i,
    output logic [3:0]  fvht_o,
    output logic [11:0] hpos_o,
    output logic [11:0] vpos_o,
    output logic        active_o,
    output logic        sof_o,
    output logic [7:0]  frame_cnt_o
);

    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    logic [11:0] hcnt_p0;
    logic [11:0] vcnt_p0;
    logic [7:0]  frame_cnt_p0;

    logic h_blank;
    logic v_blank;
    logic t_code;
    logic h_wrap;
    logic f_wrap;

    // Stage p0 -> p1: decode the current counter state before it advances.
    always_comb begin
        h_blank = (hcnt_p0 >= H_ACT);
        v_blank = (vcnt_p0 >= V_ACT);
        t_code  = (hcnt_p0 == H_ACT) || (hcnt_p0 == H_LAST);
        h_wrap  = (hcnt_p0 == H_LAST);
        f_wrap  = h_wrap && (vcnt_p0 == V_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_p0      <= '0;
            vcnt_p0      <= '0;
            frame_cnt_p0 <= '0;
            fvht_o       <= '0;
            hpos_o       <= '0;
            vpos_o       <= '0;
            active_o     <= 1'b0;
            sof_o        <= 1'b0;
            frame_cnt_o  <= '0;
        end else if (cen_i) begin
            fvht_o      <= {1'b0, v_blank, h_blank, t_code};
            hpos_o      <= hcnt_p0;
            vpos_o      <= vcnt_p0;
            active_o    <= ~h_blank & ~v_blank;
            sof_o       <= (hcnt_p0 == '0) && (vcnt_p0 == '0);
            // The frame count bumped at the last sample surfaces with the next (0,0).
            frame_cnt_o <= frame_cnt_p0;

            hcnt_p0 <= h_wrap ? '0 : hcnt_p0 + 12'd1;
            if (h_wrap) begin
                vcnt_p0 <= f_wrap ? '0 : vcnt_p0 + 12'd1;
            end
            if (f_wrap) begin
                frame_cnt_p0 <= frame_cnt_p0 + 8'd1;
            end
        end
    end

endmodule
